// File: rtl/neuron_mac.sv
// Streaming sign-magnitude multiply-accumulate neuron: NUM_IN (x, w) pairs plus bias,
// saturated to an N-bit sign-magnitude pre-activation value.
module neuron_mac #(
  parameter int Q      = 15,
  parameter int N      = 32,
  parameter int NUM_IN = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] bias,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf,
  output logic         busy
);

  localparam int MW = N - 1;
  localparam int PW = 2 * MW - Q;
  localparam int CW = $clog2(NUM_IN + 1);
  localparam int AW = PW + CW + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         prod_mag_q, prod_mag_d;
  logic                  prod_sign_q, prod_sign_d;
  logic                  prod_vld_q, prod_vld_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  out_valid_q, out_valid_d;
  logic [N-1:0]          out_sum_q, out_sum_d;
  logic                  out_ovf_q, out_ovf_d;

  logic [2*MW-1:0]       x_ext, w_ext, prod_full;
  logic signed [AW-1:0]  prod_s, bias_ext, bias_tc, acc_sum, sat_max;
  logic [AW-1:0]         acc_abs;
  logic                  acc_neg;
  logic [N-1:0]          sat_sum;
  logic                  sat_ovf;
  logic                  unused_bits;

  assign x_ext     = {{MW{1'b0}}, in_x[MW-1:0]};
  assign w_ext     = {{MW{1'b0}}, in_w[MW-1:0]};
  assign prod_full = x_ext * w_ext;

  assign prod_s   = prod_sign_q ? -signed'({{(AW-PW){1'b0}}, prod_mag_q})
                                :  signed'({{(AW-PW){1'b0}}, prod_mag_q});
  assign bias_ext = signed'({{(AW-MW){1'b0}}, bias[MW-1:0]});
  assign bias_tc  = bias[N-1] ? -bias_ext : bias_ext;
  assign acc_sum  = acc_q + prod_s;

  // Largest representable magnitude; the negative bound is symmetric.
  assign sat_max = signed'({{(AW-MW){1'b0}}, {MW{1'b1}}});
  assign acc_neg = acc_sum < 0;
  assign acc_abs = acc_neg ? -acc_sum : acc_sum;

  always_comb begin
    sat_sum = {acc_neg, acc_abs[MW-1:0]};
    sat_ovf = 1'b0;
    if (acc_sum > sat_max) begin
      sat_sum = {1'b0, {MW{1'b1}}};
      sat_ovf = 1'b1;
    end else if (acc_sum < -sat_max) begin
      sat_sum = {1'b1, {MW{1'b1}}};
      sat_ovf = 1'b1;
    end
  end

  assign unused_bits = &{prod_full[Q-1:0], acc_abs[AW-1:MW]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_mag_d  = prod_mag_q;
    prod_sign_d = prod_sign_q;
    prod_vld_d  = 1'b0;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    if (prod_vld_q) acc_d = acc_sum;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias_tc;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          prod_mag_d  = prod_full[2*MW-1:Q];
          prod_sign_d = in_x[N-1] ^ in_w[N-1];
          prod_vld_d  = 1'b1;
          cnt_d       = cnt_q + CW'(1);
          if (cnt_q == CW'(NUM_IN - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The final product lands in acc_sum this cycle, so the result is taken from it.
        out_valid_d = 1'b1;
        out_sum_d   = sat_sum;
        out_ovf_d   = sat_ovf;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_ovf_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prod_mag_q  <= '0;
      prod_sign_q <= 1'b0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_mag_q  <= prod_mag_d;
      prod_sign_q <= prod_sign_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed and randomized checks of neuron_mac (NUM_IN=4) against an integer reference model.
module tb_neuron_mac;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_w = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] xs [NI];
  logic [31:0] ws [NI];
  bit          pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  neuron_mac #(.Q(15), .N(32), .NUM_IN(NI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint sm_val(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  // Reference: exact integer arithmetic, then clamp to +/-(2^31-1) and re-encode.
  function automatic logic [32:0] model(input logic [31:0] b);
    longint acc, mx, mw, p;
    acc = sm_val(b);
    for (int i = 0; i < NI; i++) begin
      mx = longint'(xs[i][30:0]);
      mw = longint'(ws[i][30:0]);
      p  = (mx * mw) >>> 15;
      acc += (xs[i][31] ^ ws[i][31]) ? -p : p;
    end
    if (acc > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
    else if (acc < -64'sd2147483647) return {1'b1, 32'hFFFF_FFFF};
    else if (acc < 0)                return {1'b0, 1'b1, 31'(-acc)};
    else                             return {1'b0, 1'b0, 31'(acc)};
  endfunction

  task automatic set_all(input logic [31:0] x, input logic [31:0] w);
    for (int i = 0; i < NI; i++) begin
      xs[i] = x;
      ws[i] = w;
    end
  endtask

  task automatic set_rand(input bit full);
    for (int i = 0; i < NI; i++) begin
      if (full) begin
        xs[i] = $urandom;
        ws[i] = $urandom;
      end else begin
        xs[i] = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0003_FFFF))};
        ws[i] = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0003_FFFF))};
      end
    end
  endtask

  // gap_mode: 0 back-to-back, 1 fixed bubble pattern, 2 random bubbles.
  task automatic eval(input string tag, input logic [31:0] b, input int gap_mode,
                      input int stall, input bit spur);
    logic [32:0] exp_r;
    logic        v;
    int          idx, cyc;
    exp_r = model(b);
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    if (spur) begin
      in_valid = 1'b1;
      in_x = $urandom;
      in_w = $urandom;
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    bias     = $urandom;
    idx = 0;
    cyc = 0;
    while (idx < NI && cyc < 64) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = pat[cyc % 7];
        default: v = 1'($urandom_range(0, 1));
      endcase
      chk({tag, "_in_ready_accum"}, in_ready, 1);
      in_valid = v;
      in_x  = v ? xs[idx] : $urandom;
      in_w  = v ? ws[idx] : $urandom;
      start = spur && (cyc == 1);
      if (v) idx++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_beats"}, idx, NI);
    start    = 1'b0;
    in_valid = 1'b1;
    in_x     = $urandom;
    in_w     = $urandom;
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_ready"}, in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, exp_r[31:0]);
    chk({tag, "_ovf"}, out_ovf, exp_r[32]);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_sum"}, out_sum, exp_r[31:0]);
      chk({tag, "_stall_ready"}, in_ready, 0);
      chk({tag, "_stall_busy"}, busy, 1);
    end
    out_ready = 1'b1;
    start     = spur;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    in_valid = 1'b1;
    in_x = 32'h0000_8000;
    in_w = 32'h0000_4000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_in_valid_busy", busy, 0);

    set_all(32'h0000_8000, 32'h0000_4000);
    eval("basic", 32'h0000_0000, 0, 0, 1'b0);
    chk("basic_const", model(32'h0), {1'b0, 32'h0001_0000});

    set_all(32'h8000_8000, 32'h0000_4000);
    eval("signed", 32'h0000_2000, 0, 0, 1'b0);
    set_all(32'h8000_8000, 32'h0000_0000);
    eval("negzero", 32'h8000_0000, 0, 1, 1'b0);

    set_all(32'h7FFF_FFFF, 32'h00FF_8000);
    eval("sat_pos", 32'h0, 0, 0, 1'b0);
    set_all(32'hFFFF_FFFF, 32'h00FF_8000);
    eval("sat_neg", 32'h0, 0, 0, 1'b0);

    set_all(32'h0000_8000, 32'h0000_4000);
    eval("bubbles", 32'h0, 1, 5, 1'b0);
    eval("spurious", 32'h0, 1, 2, 1'b1);

    set_all(32'h0001_8000, 32'h8000_C000);
    @(negedge clk);
    start = 1'b1;
    bias  = 32'h0000_1234;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_x = xs[0];
    in_w = ws[0];
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", out_sum, 0);
    chk("abort_ovf", out_ovf, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_rand(1'b0);
    eval("after_rst", 32'h8000_4000, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      set_rand(r >= 4);
      eval("rand", {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h000F_FFFF))},
           2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Streaming multiply-accumulate neuron stage that sits directly upstream of the leaky-ReLU activation.
- Accepts NUM_IN (input, weight) pairs over a valid/ready handshake and adds a bias.
- Emits one saturated N-bit fixed-point pre-activation value that the activation stage consumes unchanged.
- All data is sign-magnitude fixed point: bit N-1 is the sign, bits N-2:0 are the magnitude, and the low Q bits are fraction.

Parameters:
- Q, 15, number of fractional bits
- N, 32, data width including the sign bit
- NUM_IN, 16, number of input/weight pairs per neuron evaluation (must be >= 1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins an evaluation; honoured only in IDLE
- bias  in  N  sign-magnitude bias; sampled on the accepted start
- in_valid  in  1  in_x/in_w pair valid
- in_ready  out  1  block can accept a pair
- in_x  in  N  sign-magnitude activation input
- in_w  in  N  sign-magnitude weight
- out_valid  out  1  out_sum valid
- out_ready  in  1  downstream accepts out_sum
- out_sum  out  N  sign-magnitude saturated result
- out_ovf  out  1  result was saturated; qualified by out_valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready, out_valid, out_ovf, busy = 0; out_sum = 0; beat counter, product register and accumulator = 0.
- States: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - in_ready=0.
  - On start=1: accumulator loads bias converted to two's complement, counter=0, go to ACCUM.
- ACCUM:
  - in_ready=1. Beat accepted when in_valid && in_ready.
  - Stage 1, each accepted beat: registered product magnitude = (|x|*|w|) >> Q (truncation, no rounding), width 2(N-1)-Q; sign = x[N-1]^w[N-1]. Product valid flag set for one cycle.
  - Stage 2: when the product valid flag is set, accumulator += signed product. Accumulator is two's complement, width 2(N-1)-Q+clog2(NUM_IN+1)+2, so it never wraps internally.
  - Counter increments per accepted beat. On the beat where counter==NUM_IN-1 is accepted, go to DRAIN.
  - Bubbles (in_valid=0) are allowed at any point and do not advance the counter.
- DRAIN:
  - in_ready=0. The last product is added. Go to OUT.
- OUT:
  - Result is registered on entry, so out_valid rises 2 cycles after the last accepted beat.
  - If acc > 2^(N-1)-1: out_sum = 0x7FFF_FFFF (N=32), out_ovf=1.
  - If acc < -(2^(N-1)-1): out_sum = 0xFFFF_FFFF, out_ovf=1.
  - Otherwise out_sum = sign-magnitude of acc, out_ovf=0. Zero is always encoded +0 (never 0x8000_0000).
  - out_valid, out_sum and out_ovf hold stable until out_ready=1. On the handshake cycle go to IDLE with out_valid=0 next cycle.
- Throughput: one pair per cycle in ACCUM. Minimum evaluation = 1 (start) + NUM_IN + 1 (DRAIN) + 1 (OUT handshake) cycles.
- Boundary conditions:
  - start outside IDLE is ignored.
  - start and out_ready in the same OUT cycle: start is ignored; the block returns to IDLE.
  - in_valid outside ACCUM is ignored; no beat is consumed.
  - Asserting rst_n=0 mid-evaluation aborts immediately to reset values. The partial result is never emitted.
  - NUM_IN=1: ACCUM lasts exactly one accepted beat.

Test Plan (NUM_IN=4, Q=15, N=32):
- Basic sum: bias=0, four beats x=0x0000_8000 (1.0), w=0x0000_4000 (0.5), out_ready=1 -> out_sum=0x0001_0000 (2.0), out_ovf=0, out_valid rises 2 cycles after the 4th beat.
- Signed mix: bias=0x0000_2000 (0.25), four beats x=0x8000_8000 (-1.0), w=0x0000_4000 -> out_sum=0x8000_E000 (-1.75). Repeat with all w=0 and bias=0x8000_0000 -> out_sum=0x0000_0000 (+0).
- Saturation: bias=0, four beats x=0x7FFF_FFFF, w=0x00FF_8000 -> out_sum=0x7FFF_FFFF, out_ovf=1. Same with x sign set -> 0xFFFF_FFFF, out_ovf=1.
- Backpressure and bubbles: in_valid toggled 1,0,0,1,1,0,1 and out_ready held low 5 cycles after out_valid -> same result as the basic-sum case; out_sum stable while stalled; in_ready=0 and busy=1 throughout OUT.
- Spurious controls: start pulsed during ACCUM and in OUT coincident with out_ready; in_valid=1 while in IDLE -> no effect on the result; exactly 4 beats consumed per evaluation.
- Reset mid-op: rst_n asserted after 2 accepted beats -> all outputs 0 at once. A new evaluation after release gives the correct fresh result, with no residue from the aborted one.
